// File: rtl/toggle_period_meter_if.sv
// Measurement bundle of the toggle period meter: the sampled square wave and the published results.
interface toggle_period_meter_if #(
  parameter int CNT_W = 25
);
  logic             sig_in;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [CNT_W:0]   period;
  logic             meas_valid;
  logic             locked;
  logic             timeout_flag;

  modport master (
    input  sig_in,
    output high_cycles, low_cycles, period, meas_valid, locked, timeout_flag
  );

  modport slave (
    output sig_in,
    input  high_cycles, low_cycles, period, meas_valid, locked, timeout_flag
  );
endinterface

// File: rtl/toggle_period_meter.sv
// Times high/low phases and full period of a slow asynchronous square wave in sys_clk cycles.
// Latency: results and meas_valid register two clocks after sig_in is first sampled changed.
// No backpressure: meas_valid is a one-cycle strobe that the consumer must catch.
module toggle_period_meter #(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] TIMEOUT = 25'd29_999_999
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  toggle_period_meter_if.master meas
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_at_max;
  logic             wr_en;
  logic             stall_en;
  logic             resume_en;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] low_q;
  logic [CNT_W:0]   period_q;
  logic             meas_vld_q;
  logic             locked_q;
  logic             timeout_q;
  logic             fresh_hi;
  logic             fresh_lo;

  assign edge_det   = sync2 ^ prev;
  assign cnt_inc    = cnt + CNT_W'(1);
  assign cnt_at_max = (cnt == TIMEOUT);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= meas.sig_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (edge_det)
        cnt <= '0;
      else if (!cnt_at_max)
        cnt <= cnt_inc;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edge_det) state_d = MEASURE;
      MEASURE: if (!edge_det && cnt_at_max) state_d = STALLED;
      STALLED: if (edge_det) state_d = MEASURE;
      default: state_d = IDLE;
    endcase
  end

  // An edge coinciding with a saturated counter is still a valid measurement.
  always_comb begin
    wr_en     = 1'b0;
    stall_en  = 1'b0;
    resume_en = 1'b0;
    case (state_q)
      MEASURE: begin
        wr_en    = edge_det;
        stall_en = !edge_det && cnt_at_max;
      end
      STALLED: resume_en = edge_det;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      high_q     <= '0;
      low_q      <= '0;
      period_q   <= '0;
      meas_vld_q <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      fresh_hi   <= 1'b0;
      fresh_lo   <= 1'b0;
    end else begin
      meas_vld_q <= wr_en;
      if (wr_en) begin
        // prev still holds the level of the phase that just ended
        if (prev) begin
          high_q   <= cnt_inc;
          period_q <= {1'b0, cnt_inc} + {1'b0, low_q};
          fresh_hi <= 1'b1;
          locked_q <= fresh_lo;
        end else begin
          low_q    <= cnt_inc;
          period_q <= {1'b0, cnt_inc} + {1'b0, high_q};
          fresh_lo <= 1'b1;
          locked_q <= fresh_hi;
        end
      end else if (stall_en) begin
        timeout_q <= 1'b1;
        locked_q  <= 1'b0;
        fresh_hi  <= 1'b0;
        fresh_lo  <= 1'b0;
      end else if (resume_en) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign meas.high_cycles  = high_q;
  assign meas.low_cycles   = low_q;
  assign meas.period       = period_q;
  assign meas.meas_valid   = meas_vld_q;
  assign meas.locked       = locked_q;
  assign meas.timeout_flag = timeout_q;

endmodule

// File: tb/tb_toggle_period_meter.sv
// Bench for toggle_period_meter: directed phases plus random phase lengths against a run-length model.
module tb_toggle_period_meter;

  localparam int               CNT_W = 25;
  localparam logic [CNT_W-1:0] TMO   = 25'd20;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  toggle_period_meter_if #(.CNT_W(CNT_W)) mif ();

  toggle_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TMO)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .meas    (mif)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] lo;
    logic [CNT_W:0]   per;
    logic             vld;
    logic             lck;
    logic             tf;
  } exp_t;

  typedef enum int {M_IDLE, M_MEAS, M_STALL} mmode_t;

  int     n_chk = 0;
  int     n_err = 0;
  exp_t   m;
  exp_t   d1;
  exp_t   d2;
  exp_t   e;
  mmode_t mode;
  logic   lv;
  int     run_len;
  logic   fh;
  logic   fl;
  logic   lvl;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m       = '0;
    d1      = '0;
    d2      = '0;
    mode    = M_IDLE;
    lv      = 1'b0;
    run_len = 0;
    fh      = 1'b0;
    fl      = 1'b0;
  endtask

  // Model works on runs of equal samples: a run ending in measure mode yields its length,
  // a run growing beyond TIMEOUT+1 samples in measure mode declares a stall.
  task automatic model_sample(input logic x);
    m.vld = 1'b0;
    if (x !== lv) begin
      if (mode == M_MEAS) begin
        if (lv) begin
          m.hi = CNT_W'(run_len);
          fh   = 1'b1;
        end else begin
          m.lo = CNT_W'(run_len);
          fl   = 1'b1;
        end
        m.per = {1'b0, m.hi} + {1'b0, m.lo};
        m.lck = fh && fl;
        m.vld = 1'b1;
      end
      if (mode == M_STALL) m.tf = 1'b0;
      mode    = M_MEAS;
      lv      = x;
      run_len = 1;
    end else begin
      run_len++;
      if (mode == M_MEAS && run_len == int'(TMO) + 2) begin
        mode  = M_STALL;
        m.tf  = 1'b1;
        m.lck = 1'b0;
        fh    = 1'b0;
        fl    = 1'b0;
      end
    end
  endtask

  // One clock: drive, let the DUT sample, advance the model, compare one tick after the edge.
  task automatic step(input logic x, input logic rst);
    sys_rst    = rst;
    mif.sig_in = x;
    @(posedge sys_clk);
    if (rst) begin
      model_reset();
      e = '0;
    end else begin
      e  = d2;
      d2 = d1;
      model_sample(x);
      d1 = m;
    end
    #1;
    check_val("high_cycles",  64'(mif.high_cycles),  64'(e.hi));
    check_val("low_cycles",   64'(mif.low_cycles),   64'(e.lo));
    check_val("period",       64'(mif.period),       64'(e.per));
    check_val("meas_valid",   64'(mif.meas_valid),   64'(e.vld));
    check_val("locked",       64'(mif.locked),       64'(e.lck));
    check_val("timeout_flag", 64'(mif.timeout_flag), 64'(e.tf));
  endtask

  task automatic hold(input logic x, input int n);
    for (int i = 0; i < n; i++) step(x, 1'b0);
  endtask

  initial begin
    model_reset();
    mif.sig_in = 1'b0;

    // Reset held while the input toggles every 4 clocks
    for (int i = 0; i < 5; i++) step(((i / 4) % 2) == 1, 1'b1);

    // 10 high / 6 low square wave
    for (int p = 0; p < 5; p++) begin
      hold(1'b1, 10);
      hold(1'b0, 6);
    end
    hold(1'b1, 3);
    check_val("sq_high",   64'(mif.high_cycles), 64'd10);
    check_val("sq_low",    64'(mif.low_cycles),  64'd6);
    check_val("sq_period", 64'(mif.period),      64'd16);
    check_val("sq_valid",  64'(mif.meas_valid),  64'd1);
    check_val("sq_locked", 64'(mif.locked),      64'd1);

    // Toggle every clock
    for (int i = 0; i < 20; i++) step((i % 2) == 1, 1'b0);
    check_val("fast_high",   64'(mif.high_cycles), 64'd1);
    check_val("fast_low",    64'(mif.low_cycles),  64'd1);
    check_val("fast_period", 64'(mif.period),      64'd2);
    check_val("fast_valid",  64'(mif.meas_valid),  64'd1);

    // Lock on 5/5, then stall
    for (int p = 0; p < 3; p++) begin
      hold(1'b0, 5);
      hold(1'b1, 5);
    end
    hold(1'b1, 30);
    check_val("stall_flag",   64'(mif.timeout_flag), 64'd1);
    check_val("stall_locked", 64'(mif.locked),       64'd0);
    check_val("stall_high",   64'(mif.high_cycles),  64'd5);
    check_val("stall_low",    64'(mif.low_cycles),   64'd5);
    check_val("stall_period", 64'(mif.period),       64'd10);
    hold(1'b0, 3);
    check_val("resume_flag",  64'(mif.timeout_flag), 64'd0);
    check_val("resume_valid", 64'(mif.meas_valid),   64'd0);
    hold(1'b0, 3);
    hold(1'b1, 3);
    check_val("relock_first", 64'(mif.locked), 64'd0);
    hold(1'b1, 2);
    hold(1'b0, 5);
    hold(1'b1, 3);
    check_val("relock_locked", 64'(mif.locked),     64'd1);
    check_val("relock_low",    64'(mif.low_cycles), 64'd5);

    // Edge exactly when the counter saturates
    hold(1'b0, 21);
    hold(1'b1, 3);
    check_val("edge_at_max_low",  64'(mif.low_cycles),   64'd21);
    check_val("edge_at_max_flag", 64'(mif.timeout_flag), 64'd0);

    // Reset in the middle of a phase while locked
    hold(1'b1, 5);
    step(1'b1, 1'b1);
    check_val("midrst_high",   64'(mif.high_cycles), 64'd0);
    check_val("midrst_locked", 64'(mif.locked),      64'd0);
    hold(1'b1, 4);
    check_val("midrst_idle_valid", 64'(mif.meas_valid), 64'd0);
    hold(1'b0, 5);

    // Random phase lengths, some beyond the timeout, with occasional resets
    lvl = 1'b1;
    for (int p = 0; p < 200; p++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(lvl, 1'b1);
        step(lvl, 1'b1);
      end
      hold(lvl, int'($urandom_range(1, 24)));
      lvl = ~lvl;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
